spic_xfer: RTL and testbench

SPIC_XFER -- requirements
Module: spic_xfer

---
 rtl/spic_pkg.sv | 15 +
 rtl/spic_clkgen.sv | 48 ++++
 rtl/spic_xfer.sv | 178 +++++++++++++++++
 tb/tb_spic_xfer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spic_pkg.sv
// Shared types and constants for the SPI controller transfer engine.
package spic_pkg;

    localparam int unsigned SPIC_DWIDTH_DEFAULT  = 32;
    localparam int unsigned SPIC_NSLAVES_DEFAULT = 4;
    localparam int unsigned SPIC_LEN_WIDTH       = $clog2(SPIC_DWIDTH_DEFAULT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2,
        StHold  = 2'd3
    } spic_xfer_state_t;

endpackage

// File: rtl/spic_clkgen.sv
// Half-period counter for the SPI clock; emits a tick at the end of every
// half-period and splits SHIFT-phase ticks into leading/trailing edge strobes.
module spic_clkgen #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 shift_en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick,
    output logic                 lead_edge,
    output logic                 trail_edge
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 phase_q, phase_d;

    always_comb begin
        tick    = en && (cnt_q == div);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
        // Phase 0 is the first half of each bit, so its end is the leading edge.
        if (!shift_en) begin
            phase_d = 1'b0;
        end else if (tick) begin
            phase_d = ~phase_q;
        end
        lead_edge  = tick && shift_en && !phase_q;
        trail_edge = tick && shift_en && phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spic_xfer.sv
// SPI master transfer engine: one command in, one full-duplex frame out.
// Optional internal loopback input is built when SPIC_LOOPBACK_EN is defined.
module spic_xfer
    import spic_pkg::*;
#(
    parameter int unsigned DWIDTH    = SPIC_DWIDTH_DEFAULT,
    parameter int unsigned NSLAVES   = SPIC_NSLAVES_DEFAULT,
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [$clog2(NSLAVES)-1:0] cmd_ss,
    input  logic [$clog2(DWIDTH)-1:0]  cmd_len,
    input  logic [DWIDTH-1:0]          cmd_data,
    input  logic                       cpol,
    input  logic                       cpha,
    input  logic [DIV_WIDTH-1:0]       clk_div,
    output logic                       rsp_valid,
    output logic [DWIDTH-1:0]          rsp_data,
    output logic                       busy,
    output logic                       sclk,
    output logic                       mosi,
    input  logic                       miso,
`ifdef SPIC_LOOPBACK_EN
    input  logic                       loopback,
`endif
    output logic [NSLAVES-1:0]         ss_n
);

    localparam int unsigned LW = $clog2(DWIDTH);
    localparam int unsigned SW = $clog2(NSLAVES);

    spic_xfer_state_t     state_q, state_d;
    logic [SW-1:0]        ss_q, ss_d;
    logic [LW-1:0]        bit_idx_q, bit_idx_d;
    logic [DWIDTH-1:0]    data_q, data_d;
    logic [DWIDTH-1:0]    rx_q, rx_d;
    logic [DWIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 live_q;

    logic tick, lead_edge, trail_edge;
    logic lb_on, sample_bit, cmd_accept;

`ifdef SPIC_LOOPBACK_EN
    assign lb_on = loopback;
`else
    assign lb_on = 1'b0;
`endif

    assign sample_bit = lb_on ? mosi_q : miso;
    // No accept in the rsp_valid cycle, so ss_n always shows a high gap.
    assign cmd_ready  = (state_q == StIdle) && live_q && !rsp_valid_q;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign busy       = (state_q != StIdle);
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

    spic_clkgen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q != StIdle),
        .shift_en  (state_q == StShift),
        .div       (div_q),
        .tick      (tick),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge)
    );

    always_comb begin
        ss_n = '1;
        if (state_q != StIdle && !lb_on && 32'(ss_q) < NSLAVES) begin
            ss_n[ss_q] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        ss_d        = ss_q;
        bit_idx_d   = bit_idx_q;
        data_d      = data_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        div_d       = div_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    state_d   = StSetup;
                    ss_d      = cmd_ss;
                    bit_idx_d = cmd_len;
                    data_d    = cmd_data;
                    div_d     = clk_div;
                    cpol_d    = cpol;
                    cpha_d    = cpha;
                    sclk_d    = cpol;
                    mosi_d    = cmd_data[cmd_len];
                    rx_d      = '0;
                end
            end
            StSetup: begin
                if (tick) state_d = StShift;
            end
            StShift: begin
                if (tick) sclk_d = ~sclk_q;
                if (lead_edge) begin
                    if (!cpha_q) rx_d = {rx_q[DWIDTH-2:0], sample_bit};
                    else         mosi_d = data_q[bit_idx_q];
                end
                if (trail_edge) begin
                    if (cpha_q) rx_d = {rx_q[DWIDTH-2:0], sample_bit};
                    if (bit_idx_q == '0) begin
                        state_d = StHold;
                    end else begin
                        bit_idx_d = bit_idx_q - LW'(1);
                        if (!cpha_q) mosi_d = data_q[bit_idx_q - LW'(1)];
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ss_q        <= '0;
            bit_idx_q   <= '0;
            data_q      <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            div_q       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_q        <= ss_d;
            bit_idx_q   <= bit_idx_d;
            data_q      <= data_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            div_q       <= div_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            live_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spic_xfer.sv
// Self-checking bench for spic_xfer: behavioural SPI slave plus frame-level timing model.
module tb_spic_xfer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready, cmd_ready2;
    logic [1:0]  cmd_ss;
    logic [1:0]  cmd_ss2 = 2'd3;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        cpol, cpha;
    logic [7:0]  clk_div;
    logic        rsp_valid, rsp_valid2;
    logic [31:0] rsp_data, rsp_data2;
    logic        busy, busy2, sclk, sclk2, mosi, mosi2, miso;
    logic [3:0]  ss_n;
    logic [2:0]  ss_n2;
    logic        loopback = 1'b0;

    int errors = 0;
    int checks = 0;

    // Slave model state
    logic        lb_mode = 1'b0;
    logic        miso_reg = 1'b0;
    logic        cur_cpol = 1'b0, cur_cpha = 1'b0;
    int          cur_len = 0;
    logic [31:0] sl_word = '0;
    logic [31:0] sl_rx = '0;
    int          sl_idx = 0;
    int          sclk_edges = 0;
    logic        prev_busy = 1'b0, prev_sclk = 1'b0;

    always #5 clk = ~clk;

    assign miso = lb_mode ? mosi : miso_reg;

    spic_xfer u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ss   (cmd_ss),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
`ifdef SPIC_LOOPBACK_EN
        .loopback (loopback),
`endif
        .ss_n     (ss_n)
    );

    spic_xfer #(
        .NSLAVES(3)
    ) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready2),
        .cmd_ss   (cmd_ss2),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
        .rsp_valid(rsp_valid2),
        .rsp_data (rsp_data2),
        .busy     (busy2),
        .sclk     (sclk2),
        .mosi     (mosi2),
        .miso     (mosi2),
`ifdef SPIC_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .ss_n     (ss_n2)
    );

    // SPI slave: shifts its word out MSB-first and records what it receives.
    always @(sclk or busy) begin
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            sl_idx     = cur_len;
            miso_reg   = sl_word[cur_len];
            sl_rx      = '0;
            sclk_edges = 0;
        end else if (busy === 1'b1 && rst_n === 1'b1 && sclk !== prev_sclk) begin
            sclk_edges++;
            if (sclk !== cur_cpol) begin
                if (cur_cpha) begin
                    if (sl_idx >= 0) miso_reg = sl_word[sl_idx];
                end else begin
                    sl_rx = {sl_rx[30:0], mosi};
                end
            end else begin
                if (cur_cpha) begin
                    sl_rx = {sl_rx[30:0], mosi};
                    sl_idx--;
                end else begin
                    sl_idx--;
                    if (sl_idx >= 0) miso_reg = sl_word[sl_idx];
                end
            end
        end
        prev_busy = busy;
        prev_sclk = sclk;
    end

    // src: 0 = slave drives miso, 1 = miso wired to mosi, 2 = DUT loopback input
    task automatic xfer(input string name, input logic [1:0] ss, input int len,
                        input logic [31:0] data, input logic pol, input logic pha,
                        input int div, input logic [31:0] sword, input int src);
        int          h, n, flen, w, lat, lat2, ss_bad, ss2_bad, sclk_bad, st_bad, pulse_bad;
        logic [31:0] mask, exp_rsp, got_rsp, got_rsp2;
        logic [3:0]  exp_ss;
        logic        exp_sclk;
        h = div + 1;
        n = len + 1;
        flen = (2 * n + 2) * h;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        exp_rsp = (src == 0) ? (sword & mask) : (data & mask);
        lat = -1; lat2 = -1; ss_bad = 0; ss2_bad = 0; sclk_bad = 0; st_bad = 0; pulse_bad = 0;
        cur_cpol = pol; cur_cpha = pha; cur_len = len; sl_word = sword;
        lb_mode = (src == 1);
        loopback = (src == 2);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ss = ss; cmd_len = len[4:0]; cmd_data = data;
        cpol = pol; cpha = pha; clk_div = div[7:0];
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: cmd_ready=%b required 1", name, cmd_ready);
        end
        @(posedge clk);
        for (int k = 1; k <= flen + 2; k++) begin
            @(negedge clk);
            exp_ss = (k <= flen && src != 2) ? ~(4'b0001 << ss) : 4'hF;
            if (ss_n !== exp_ss) ss_bad++;
            if (ss_n2 !== 3'b111) ss2_bad++;
            if (k <= h || k > h + 2 * n * h) exp_sclk = pol;
            else exp_sclk = pol ^ (((k - 1 - h) / h) % 2 == 1);
            if (sclk !== exp_sclk) sclk_bad++;
            if (busy !== (k <= flen)) st_bad++;
            if (k <= flen + 1 && cmd_ready !== 1'b0) st_bad++;
            if (rsp_valid === 1'b1 && lat < 0) lat = k;
            if (rsp_valid2 === 1'b1 && lat2 < 0) lat2 = k;
            if (k == flen + 2 && rsp_valid !== 1'b0) pulse_bad++;
            if (k == 1) begin
                // Scramble command inputs: the frame must use the captured values.
                cmd_valid = 1'b0;
                cmd_data = $urandom; cmd_len = 5'($urandom); cmd_ss = 2'($urandom);
                cpol = ~pol; cpha = ~pha; clk_div = 8'($urandom);
            end
        end
        got_rsp = rsp_data;
        got_rsp2 = rsp_data2;
        checks++;
        if (lat != flen + 1) begin
            errors++;
            $display("FAIL %s latency: rsp_valid at T+%0d required T+%0d", name, lat, flen + 1);
        end
        checks++;
        if (lat2 != flen + 1) begin
            errors++;
            $display("FAIL %s latency3: rsp_valid at T+%0d required T+%0d", name, lat2, flen + 1);
        end
        checks++;
        if (got_rsp !== exp_rsp) begin
            errors++;
            $display("FAIL %s rsp_data: got %h required %h", name, got_rsp, exp_rsp);
        end
        checks++;
        if (got_rsp2 !== (data & mask)) begin
            errors++;
            $display("FAIL %s rsp_data3: got %h required %h", name, got_rsp2, data & mask);
        end
        checks++;
        if (sl_rx !== (data & mask)) begin
            errors++;
            $display("FAIL %s slave_rx: got %h required %h", name, sl_rx, data & mask);
        end
        checks++;
        if (sclk_edges != 2 * n) begin
            errors++;
            $display("FAIL %s sclk_edges: got %0d required %0d", name, sclk_edges, 2 * n);
        end
        checks++;
        if (ss_bad != 0 || ss2_bad != 0) begin
            errors++;
            $display("FAIL %s ss_n: bad cycles %0d/%0d required 0/0", name, ss_bad, ss2_bad);
        end
        checks++;
        if (sclk_bad != 0) begin
            errors++;
            $display("FAIL %s sclk: bad cycles %0d required 0", name, sclk_bad);
        end
        checks++;
        if (st_bad != 0 || pulse_bad != 0) begin
            errors++;
            $display("FAIL %s busy/ready/pulse: bad %0d/%0d required 0/0", name, st_bad,
                     pulse_bad);
        end
        lb_mode = 1'b0;
        loopback = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_ss = '0; cmd_len = '0; cmd_data = '0;
        cpol = 1'b0; cpha = 1'b0; clk_div = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ss_n, sclk, mosi, busy, rsp_valid, cmd_ready} !== {4'hF, 5'b0}) begin
            errors++;
            $display("FAIL reset_outputs: ss_n/sclk/mosi/busy/rsp_valid/ready=%b required %b",
                     {ss_n, sclk, mosi, busy, rsp_valid, cmd_ready}, {4'hF, 5'b0});
        end
        checks++;
        if (rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp_data: got %h required 00000000", rsp_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_abort();
        int w, seen;
        cur_cpol = 1'b1; cur_cpha = 1'b1; cur_len = 15; sl_word = $urandom;
        lb_mode = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ss = 2'd1; cmd_len = 5'd15; cmd_data = $urandom;
        cpol = 1'b1; cpha = 1'b1; clk_div = 8'd1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        // H=2: SETUP is T+1..T+2, bit 4 leading half starts at T+19.
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ss_n !== 4'hF || ss_n2 !== 3'b111 || sclk !== 1'b0) begin
            errors++;
            $display("FAIL abort_lines: ss_n=%b ss_n3=%b sclk=%b required 1111 111 0",
                     ss_n, ss_n2, sclk);
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b0 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: busy=%b ready=%b rsp_data=%h required 0 0 00000000",
                     busy, cmd_ready, rsp_data);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        rst_n = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid cycles %0d required 0", seen);
        end
        lb_mode = 1'b0;
        xfer("after_abort", 2'd1, 15, $urandom, 1'b1, 1'b1, 1, $urandom, 0);
    endtask

    task automatic test_back_to_back();
        int          w, r, a, r2;
        logic [31:0] d1, d2, rd1, rd2;
        logic [3:0]  s0, s1, s2;
        d1 = $urandom; d2 = $urandom;
        r = -1; a = -1; r2 = -1; rd1 = '0; rd2 = '0; s0 = '0; s1 = '0; s2 = '0;
        cur_cpol = 1'b0; cur_cpha = 1'b0; cur_len = 3;
        lb_mode = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ss = 2'd0; cmd_len = 5'd3; cmd_data = d1;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) cmd_data = d2;
            if (rsp_valid === 1'b1 && r < 0) begin
                r = k; rd1 = rsp_data;
            end else if (rsp_valid === 1'b1 && r >= 0 && r2 < 0) begin
                r2 = k; rd2 = rsp_data;
            end
            if (a >= 0 && k == a + 1) cmd_valid = 1'b0;
            if (r >= 0 && a < 0 && k > r && cmd_ready === 1'b1) a = k;
            if (r >= 0 && k == r) s0 = ss_n;
            if (r >= 0 && k == r + 1) s1 = ss_n;
            if (r >= 0 && k == r + 2) s2 = ss_n;
        end
        cmd_valid = 1'b0;
        lb_mode = 1'b0;
        checks++;
        if (r != 11) begin
            errors++;
            $display("FAIL b2b_first_rsp: at T+%0d required T+11", r);
        end
        checks++;
        if (a != r + 1) begin
            errors++;
            $display("FAIL b2b_accept: second accept at T+%0d required T+%0d", a, r + 1);
        end
        checks++;
        if (s0 !== 4'hF || s1 !== 4'hF || s2 !== 4'hE) begin
            errors++;
            $display("FAIL b2b_ss_gap: ss_n %b %b %b required 1111 1111 1110", s0, s1, s2);
        end
        checks++;
        if (r2 != a + 11) begin
            errors++;
            $display("FAIL b2b_second_rsp: at T+%0d required T+%0d", r2, a + 11);
        end
        checks++;
        if (rd1 !== (d1 & 32'hF) || rd2 !== (d2 & 32'hF)) begin
            errors++;
            $display("FAIL b2b_data: got %h %h required %h %h", rd1, rd2, d1 & 32'hF,
                     d2 & 32'hF);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            xfer("random", 2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom,
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), $urandom,
                 int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        xfer("mode0_a5", 2'd0, 7, 32'h0000_00A5, 1'b0, 1'b0, 0, $urandom, 1);
        xfer("mode3_deadbeef", 2'd2, 31, 32'hDEAD_BEEF, 1'b1, 1'b1, 3, $urandom, 0);
        xfer("mode1", 2'd3, 12, $urandom, 1'b0, 1'b1, 2, $urandom, 0);
        xfer("mode2", 2'd1, 0, $urandom, 1'b1, 1'b0, 1, $urandom, 0);
        test_abort();
        test_back_to_back();
        test_random();
`ifdef SPIC_LOOPBACK_EN
        xfer("loopback_3c", 2'd1, 7, 32'h0000_003C, 1'b0, 1'b0, 0, 32'h0000_00C3, 2);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
